// File: rtl/ecc_hamming_pkg.sv
// Shared types and sizing helpers for the Hamming/SECDED datapath and scrubber.
package ecc_hamming_pkg;

  typedef enum logic [2:0] {
    IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT
  } scrub_state_t;

  function automatic int ecc_parity_bits(int d, int c);
    return c - d;
  endfunction

  function automatic int ecc_mem_width(int dw, int c, int d, int secded);
    return dw + c - d + secded;
  endfunction

  // 1-based codeword position of data bit k (data fills the non-power-of-two slots).
  function automatic int ecc_data_pos(int k);
    int n, r;
    n = 0;
    r = 0;
    for (int p = 1; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) r = p;
        n++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ecc_hamming_decoder.sv
// Hamming/SECDED decoder: syndrome, single-bit correction, double-error flag.
module ecc_hamming_decoder import ecc_hamming_pkg::*; #(
  parameter  int D      = 4,
  parameter  int DW     = D,
  parameter  int C      = 7,
  parameter  int SECDED = 1,
  localparam int MW     = ecc_mem_width(DW, C, D, SECDED)
) (
  input  logic [MW-1:0] word,
  output logic [DW-1:0] data,
  output logic          sb_err,
  output logic          db_err
);
  localparam int P  = ecc_parity_bits(D, C);
  localparam int CW = C - (D - DW);

  logic [C-1:0] cw;
  logic [P-1:0] syn;
  logic         par;

  always_comb begin
    cw = '0;
    cw[CW-1:0] = word[CW-1:0];
    syn = '0;
    for (int q = 1; q <= C; q++) if (cw[q-1]) syn = syn ^ P'(q);
    par = ^word;
    sb_err = 1'b0;
    db_err = 1'b0;
    // A syndrome pointing past the stored bits cannot be a single error.
    if (SECDED != 0) begin
      if (par) begin
        if (int'(syn) > CW) db_err = 1'b1;
        else                sb_err = 1'b1;
      end else if (syn != '0) db_err = 1'b1;
    end else if (syn != '0) begin
      if (int'(syn) > CW) db_err = 1'b1;
      else                sb_err = 1'b1;
    end
    for (int q = 1; q <= C; q++)
      if (sb_err && int'(syn) == q) cw[q-1] = ~cw[q-1];
    data = '0;
    for (int k = 0; k < DW; k++) data[k] = cw[ecc_data_pos(k)-1];
  end

endmodule

// File: rtl/ecc_hamming_encoder.sv
// Hamming encoder with optional overall parity; shortened codes drop the top data slots.
module ecc_hamming_encoder import ecc_hamming_pkg::*; #(
  parameter  int D      = 4,
  parameter  int DW     = D,
  parameter  int C      = 7,
  parameter  int SECDED = 1,
  localparam int MW     = ecc_mem_width(DW, C, D, SECDED)
) (
  input  logic [DW-1:0] data,
  output logic [MW-1:0] word
);
  localparam int P  = ecc_parity_bits(D, C);
  localparam int CW = C - (D - DW);

  logic [D-1:0] dext;
  logic [C-1:0] cw;

  always_comb begin
    dext = '0;
    dext[DW-1:0] = data;
    cw = '0;
    for (int k = 0; k < D; k++) cw[ecc_data_pos(k)-1] = dext[k];
    for (int b = 0; b < P; b++)
      for (int q = 1; q <= C; q++)
        if (((q >> b) & 1) == 1 && q != (1 << b)) cw[(1 << b)-1] = cw[(1 << b)-1] ^ cw[q-1];
  end

  if (SECDED != 0) begin : g_secded
    assign word = {^cw[CW-1:0], cw[CW-1:0]};
  end else begin : g_plain
    assign word = cw[CW-1:0];
  end

endmodule

// File: rtl/ecc_hamming_scrubber.sv
// Background scrubber: walks memory via the arbiter, rewrites corrected words,
// counts and reports uncorrectable ones.
module ecc_hamming_scrubber import ecc_hamming_pkg::*; #(
  parameter  int D        = 4,
  parameter  int DW       = D,
  parameter  int C        = 7,
  parameter  int SECDED   = 1,
  parameter  int AW       = 8,
  parameter  int DEPTH    = 2**AW,
  parameter  int INTERVAL = 1024,
  parameter  int CNTW     = 16,
  localparam int MW       = ecc_mem_width(DW, C, D, SECDED)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            start,
  input  logic            clr_cnt,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [MW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [MW-1:0]   mem_rdata,
  output logic            busy,
  output logic            pass_done,
  output logic [CNTW-1:0] sb_cnt,
  output logic [CNTW-1:0] db_cnt,
  output logic [AW-1:0]   db_err_addr,
  output logic            db_irq
);
  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  scrub_state_t  state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [IW-1:0] ivl, ivl_n;
  logic          oneshot, oneshot_n;
  logic [MW-1:0] rword, enc_word;
  logic [DW-1:0] dec_data;
  logic          dec_sb, dec_db, last, chk_sb, chk_db;

  ecc_hamming_decoder #(.D(D), .DW(DW), .C(C), .SECDED(SECDED)) u_dec (
    .word(rword), .data(dec_data), .sb_err(dec_sb), .db_err(dec_db)
  );

  ecc_hamming_encoder #(.D(D), .DW(DW), .C(C), .SECDED(SECDED)) u_enc (
    .data(dec_data), .word(enc_word)
  );

  assign last   = (addr == AW'(DEPTH - 1));
  assign busy   = !(state == IDLE || state == WAIT);
  assign chk_sb = (state == CHECK) && dec_sb;
  assign chk_db = (state == CHECK) && dec_db;

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    ivl_n     = ivl;
    oneshot_n = oneshot;
    case (state)
      IDLE, WAIT: begin
        if (start) begin
          addr_n    = '0;
          oneshot_n = 1'b1;
          state_n   = RD_REQ;
        end else if (!enable) begin
          state_n = IDLE;
        end else if (state == IDLE) begin
          state_n = WAIT;
          ivl_n   = IW'(INTERVAL - 1);
        end else if (ivl == '0) begin
          state_n = RD_REQ;
        end else begin
          ivl_n = ivl - 1'b1;
        end
      end
      RD_REQ:  if (mem_gnt) state_n = RD_WAIT;
      RD_WAIT: if (mem_rvalid) state_n = CHECK;
      CHECK:   state_n = dec_sb ? WR_REQ : NEXT;
      WR_REQ:  if (mem_gnt) state_n = NEXT;
      NEXT: begin
        if (last) begin
          addr_n    = '0;
          oneshot_n = 1'b0;
        end else begin
          addr_n = addr + 1'b1;
        end
        if (oneshot_n) begin
          state_n = RD_REQ;
        end else if (enable) begin
          state_n = WAIT;
          ivl_n   = IW'(INTERVAL - 1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      ivl         <= '0;
      oneshot     <= 1'b0;
      rword       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      pass_done   <= 1'b0;
      sb_cnt      <= '0;
      db_cnt      <= '0;
      db_err_addr <= '0;
      db_irq      <= 1'b0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      ivl     <= ivl_n;
      oneshot <= oneshot_n;
      if (state == RD_WAIT && mem_rvalid) rword <= mem_rdata;
      // Bus outputs follow the next state so they are registered yet aligned with it.
      mem_req <= (state_n == RD_REQ) || (state_n == WR_REQ);
      mem_we  <= (state_n == WR_REQ);
      if (state_n == RD_REQ) mem_addr <= addr_n;
      if (chk_sb) mem_wdata <= enc_word;
      pass_done <= (state == NEXT) && last;
      db_irq    <= chk_db;
      if (chk_db) db_err_addr <= addr;
      if (clr_cnt)                  sb_cnt <= '0;
      else if (chk_sb && ~&sb_cnt)  sb_cnt <= sb_cnt + 1'b1;
      if (clr_cnt)                  db_cnt <= '0;
      else if (chk_db && ~&db_cnt)  db_cnt <= db_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_hamming_scrubber.sv
// Directed bench: 4-word SECDED(8,4) memory behind a single-port arbiter model.
module tb_ecc_hamming_scrubber;
  localparam int MW = 8;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, start = 1'b0, clr_cnt = 1'b0;
  logic mem_req, mem_we, mem_gnt, busy, pass_done, db_irq;
  logic mem_rvalid = 1'b0;
  logic [7:0] mem_addr, db_err_addr;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] mem_rdata = '0;
  logic [1:0] sb_cnt, db_cnt;

  logic rd_block = 1'b0, wr_block = 1'b0;
  logic poke = 1'b0;
  logic [1:0] poke_addr = '0;
  logic [7:0] poke_val = '0;
  logic [7:0] mem [4];
  logic [1:0] rv_addr = '0;
  logic [7:0] last_waddr = '0, last_wdata = '0;
  int reads = 0, writes = 0, irqs = 0;
  int n_chk = 0, n_fail = 0;

  // Clean SECDED words {p, d3 d2 d1 p4 d0 p2 p1}
  localparam logic [7:0] W0 = 8'h00;  // data 0
  localparam logic [7:0] W3 = 8'h1E;  // data 3
  localparam logic [7:0] WA = 8'hD2;  // data A
  localparam logic [7:0] W5 = 8'h2D;  // data 5

  always #5 clk = ~clk;

  ecc_hamming_scrubber #(
    .D(4), .DW(4), .C(7), .SECDED(1), .AW(8), .DEPTH(4), .INTERVAL(2), .CNTW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .clr_cnt(clr_cnt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .pass_done(pass_done), .sb_cnt(sb_cnt), .db_cnt(db_cnt),
    .db_err_addr(db_err_addr), .db_irq(db_irq)
  );

  assign mem_gnt = mem_req && !(mem_we ? wr_block : rd_block);

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (poke) mem[poke_addr] <= poke_val;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr[1:0]] <= mem_wdata;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
        writes <= writes + 1;
      end else begin
        mem_rdata  <= mem[mem_addr[1:0]];
        rv_addr    <= mem_addr[1:0];
        mem_rvalid <= 1'b1;
        reads <= reads + 1;
      end
    end
  end

  always @(negedge clk) if (db_irq) irqs <= irqs + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_poke(input logic [1:0] a, input logic [7:0] v);
    poke = 1'b1; poke_addr = a; poke_val = v;
    @(negedge clk);
    poke = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_pass(input string tag);
    int i;
    i = 0;
    while (!pass_done && i < 300) begin @(negedge clk); i++; end
    chk(tag, 32'(pass_done), 1);
    @(negedge clk);
  endtask

  initial begin
    int i, r0, w0, q0;
    logic ok;

    do_poke(0, W0); do_poke(1, W3); do_poke(2, WA); do_poke(3, W5);
    repeat (2) @(negedge clk);
    chk("rst_req",   32'({mem_req, mem_we, busy, pass_done, db_irq}), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_cnts",  32'({sb_cnt, db_cnt}), 0);
    chk("rst_dbadr", 32'(db_err_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean periodic pass
    r0 = reads; w0 = writes;
    enable = 1'b1;
    wait_pass("clean_pass_done");
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("clean_reads",  32'(reads - r0), 4);
    chk("clean_writes", 32'(writes - w0), 0);
    chk("clean_cnts",   32'({sb_cnt, db_cnt}), 0);
    chk("clean_idle",   32'({busy, mem_req}), 0);

    // Single-bit error at address 2
    do_poke(2, WA ^ 8'h04);
    w0 = writes;
    pulse_start();
    wait_pass("sb_pass_done");
    chk("sb_writes", 32'(writes - w0), 1);
    chk("sb_waddr",  32'(last_waddr), 2);
    chk("sb_wdata",  32'(last_wdata), 32'(WA));
    chk("sb_mem",    32'(mem[2]), 32'(WA));
    chk("sb_cnt1",   32'(sb_cnt), 1);

    // Double-bit error at address 3, scrubbed twice
    do_poke(3, W5 ^ 8'h03);
    w0 = writes; q0 = irqs;
    pulse_start();
    wait_pass("db_pass_done");
    chk("db_writes", 32'(writes - w0), 0);
    chk("db_cnt1",   32'(db_cnt), 1);
    chk("db_addr",   32'(db_err_addr), 3);
    chk("db_irq1",   32'(irqs - q0), 1);
    pulse_start();
    wait_pass("db_pass2_done");
    chk("db_cnt2",   32'(db_cnt), 2);
    chk("db_irq2",   32'(irqs - q0), 2);
    chk("db_sb_kept", 32'(sb_cnt), 1);

    // Arbiter withholds read grant for 10 cycles
    do_poke(3, W5);
    rd_block = 1'b1;
    r0 = reads;
    pulse_start();
    i = 0;
    while (!mem_req && i < 20) begin @(negedge clk); i++; end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 8'd0)) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_stable", 32'(ok), 1);
    chk("stall_noread", 32'(reads - r0), 0);
    rd_block = 1'b0;
    wait_pass("stall_pass_done");
    chk("stall_reads", 32'(reads - r0), 4);

    // enable dropped while a read is outstanding
    r0 = reads;
    enable = 1'b1;
    i = 0;
    while (!(mem_req && mem_gnt) && i < 50) begin @(negedge clk); i++; end
    chk("endrop_req", 32'(mem_req), 1);
    @(negedge clk);
    enable = 1'b0;
    ok = 1'b1;
    repeat (8) begin @(negedge clk); if (mem_req !== 1'b0) ok = 1'b0; end
    chk("endrop_req_low", 32'(ok), 1);
    chk("endrop_reads",   32'(reads - r0), 1);
    chk("endrop_idle",    32'(busy), 0);
    enable = 1'b1;
    i = 0;
    while (!mem_req && i < 50) begin @(negedge clk); i++; end
    chk("endrop_addr_adv", 32'(mem_addr), 1);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("endrop_idle2", 32'(busy), 0);

    // sb_cnt saturates at 3 with CNTW=2
    do_poke(1, W3 ^ 8'h10);
    do_poke(2, WA ^ 8'h04);
    pulse_start();
    wait_pass("sat_pass1_done");
    chk("sat_cnt3", 32'(sb_cnt), 3);
    do_poke(2, WA ^ 8'h40);
    pulse_start();
    wait_pass("sat_pass2_done");
    chk("sat_hold", 32'(sb_cnt), 3);

    // clr_cnt in the very cycle of an increment
    do_poke(2, WA ^ 8'h04);
    pulse_start();
    i = 0;
    while (!(mem_rvalid && rv_addr == 2'd2) && i < 100) begin @(negedge clk); i++; end
    chk("clr_found_rd2", 32'(mem_rvalid), 1);
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    wait_pass("clr_pass_done");
    chk("clr_sb", 32'(sb_cnt), 0);
    chk("clr_db", 32'(db_cnt), 0);
    chk("clr_mem2", 32'(mem[2]), 32'(WA));

    // Asynchronous reset while a write request is pending
    do_poke(1, W3 ^ 8'h10);
    wr_block = 1'b1;
    pulse_start();
    i = 0;
    while (!(mem_req && mem_we) && i < 50) begin @(negedge clk); i++; end
    chk("wr_pend_we",    32'(mem_we), 1);
    chk("wr_pend_addr",  32'(mem_addr), 1);
    chk("wr_pend_wdata", 32'(mem_wdata), 32'(W3));
    chk("wr_pend_sb",    32'(sb_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   32'({mem_req, mem_we, busy}), 0);
    chk("arst_addr",  32'(mem_addr), 0);
    chk("arst_wdata", 32'(mem_wdata), 0);
    chk("arst_sb",    32'(sb_cnt), 0);
    wr_block = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
